// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported 64-bit memory with a
// one-cycle read latency. Optional fetch starvation guard: ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int MEM_DWORDS   = 4096,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [63:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [63:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [63:0] d_rsp_data,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  // owner      | meaning
  // OWN_NONE   | no response due this cycle
  // OWN_IF     | fetch response due (word select in addr2_q)
  // OWN_D_RD   | data read response due
  // OWN_D_WR   | data write acknowledge due
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D_RD, OWN_D_WR} owner_e;

  owner_e      owner_q, owner_d;
  logic        addr2_q, addr2_d;
  logic        oor_q, oor_d;
  logic        if_gnt, d_gnt, starve_force;
  logic [63:0] gnt_dw;
  logic        gnt_in_range;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign starve_force = (starve_cnt_q >= 4'(STARVE_LIMIT));

  // Saturates so a long-waiting fetch cannot wrap back to a low count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (if_req_valid && (starve_cnt_q != 4'hF)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign starve_force = 1'b0;
`endif

  // Grants are forced low while rst_n is asserted.
  always_comb begin
    d_gnt  = rst_n & d_req_valid & ~(starve_force & if_req_valid);
    if_gnt = rst_n & if_req_valid & ~d_gnt;
  end

  always_comb begin
    if_req_ready = if_gnt;
    d_req_ready  = d_gnt;
    gnt_dw       = '0;
    if (d_gnt) begin
      gnt_dw = d_req_addr >> 3;
    end else if (if_gnt) begin
      gnt_dw = if_req_addr >> 3;
    end
    gnt_in_range = (gnt_dw < 64'(MEM_DWORDS));
    mem_en       = (d_gnt | if_gnt) & gnt_in_range;
    mem_we       = d_gnt & d_req_we & gnt_in_range;
    mem_addr     = gnt_dw;
    mem_wdata    = (d_gnt & d_req_we) ? d_req_wdata : '0;

    owner_d = OWN_NONE;
    addr2_d = 1'b0;
    oor_d   = 1'b0;
    if (d_gnt) begin
      owner_d = d_req_we ? OWN_D_WR : OWN_D_RD;
      oor_d   = ~gnt_in_range;
    end else if (if_gnt) begin
      owner_d = OWN_IF;
      addr2_d = if_req_addr[2];
      oor_d   = ~gnt_in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      addr2_q <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      addr2_q <= addr2_d;
      oor_q   <= oor_d;
    end
  end

  // Out-of-range reads never strobed the memory, so mem_rdata is stale: return 0.
  always_comb begin
    if_rsp_valid = (owner_q == OWN_IF);
    if_rsp_data  = '0;
    if (if_rsp_valid && !oor_q) begin
      if_rsp_data = addr2_q ? mem_rdata[63:32] : mem_rdata[31:0];
    end
    d_rsp_valid = (owner_q == OWN_D_RD) || (owner_q == OWN_D_WR);
    d_rsp_data  = ((owner_q == OWN_D_RD) && !oor_q) ? mem_rdata : '0;
    busy        = (owner_q != OWN_NONE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner cases and a random
// run against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        d_req_valid, d_req_ready;
  logic [63:0] d_req_addr;
  logic        d_req_we;
  logic [63:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [63:0] d_rsp_data;
  logic        mem_en, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory behind the arbiter: synchronous write, one-cycle read latency.
  logic [63:0] tb_mem [0:4095];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr[11:0]] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr[11:0]];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // kind: 0 none, 1 fetch response, 2 data response
  task automatic chk_rsp(input int kind, input logic [63:0] data);
    chk("if_rsp_valid", {63'd0, if_rsp_valid}, {63'd0, kind == 1});
    chk("d_rsp_valid",  {63'd0, d_rsp_valid},  {63'd0, kind == 2});
    chk("busy",         {63'd0, busy},         {63'd0, kind != 0});
    if (kind == 1) chk("if_rsp_data", {32'd0, if_rsp_data}, {32'd0, data[31:0]});
    if (kind == 2) chk("d_rsp_data", d_rsp_data, data);
  endtask

  task automatic drive(input logic iv, input logic [63:0] ia, input logic dv,
                       input logic [63:0] da, input logic we, input logic [63:0] wd);
    if_req_valid = iv; if_req_addr = ia;
    d_req_valid  = dv; d_req_addr  = da; d_req_we = we; d_req_wdata = wd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        iv;
    logic [63:0] ia;
    logic        dv;
    logic [63:0] da;
    logic        we;
    logic [63:0] wd;
    logic        e_ir;
    logic        e_dr;
    logic        e_en;
    logic        e_we;
    logic [63:0] e_addr;
    int          e_kind;
    logic [63:0] e_data;
  } vec_t;

  vec_t vecs [10];

  // Reference model state
  logic [63:0] ref_mem [0:15];
  int          prev_kind;
  logic [63:0] prev_data;
  int          starve_cnt;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      tb_mem[i]  <= {32'hC0DE0000 + i, 32'h00001000 + i};
      ref_mem[i] =  {32'hC0DE0000 + i, 32'h00001000 + i};
    end
    tb_mem[0] <= 64'hAAAAAAAA_BBBBBBBB;
    ref_mem[0] = 64'hAAAAAAAA_BBBBBBBB;
    tb_mem[1] <= 64'h11112222_33334444;
    ref_mem[1] = 64'h11112222_33334444;

    //            iv  ia          dv  da          we  wd          ir  dr  en  we  addr        kind data
    vecs[0] = '{1'b1, 64'h4,    1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 64'h0,    1, 64'hAAAAAAAA};
    vecs[1] = '{1'b1, 64'h0,    1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 64'h0,    1, 64'hBBBBBBBB};
    vecs[2] = '{1'b0, 64'h0,    1'b1, 64'h1100, 1'b1, 64'h7B,   1'b0, 1'b1, 1'b1, 1'b1, 64'h220,  2, 64'h0};
    vecs[3] = '{1'b0, 64'h0,    1'b1, 64'h1100, 1'b0, 64'h0,    1'b0, 1'b1, 1'b1, 1'b0, 64'h220,  2, 64'h7B};
    vecs[4] = '{1'b1, 64'h8,    1'b1, 64'h0,    1'b0, 64'h0,    1'b0, 1'b1, 1'b1, 1'b0, 64'h0,    2, 64'hAAAAAAAA_BBBBBBBB};
    vecs[5] = '{1'b1, 64'h8,    1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 64'h1,    1, 64'h33334444};
    vecs[6] = '{1'b0, 64'h0,    1'b1, 64'h8000, 1'b0, 64'h0,    1'b0, 1'b1, 1'b0, 1'b0, 64'h1000, 2, 64'h0};
    vecs[7] = '{1'b0, 64'h0,    1'b1, 64'h8000, 1'b1, 64'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0, 64'h1000, 2, 64'h0};
    vecs[8] = '{1'b1, 64'h8004, 1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 64'h1000, 1, 64'h0};
    vecs[9] = '{1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    0, 64'h0};

    // In reset with both valids high: nothing granted, everything quiet.
    rst_n = 1'b0;
    drive(1'b1, 64'h4, 1'b1, 64'h10, 1'b1, 64'h55);
    #12;
    chk("rst if_req_ready", {63'd0, if_req_ready}, 64'd0);
    chk("rst d_req_ready",  {63'd0, d_req_ready},  64'd0);
    chk("rst mem_en",       {63'd0, mem_en},       64'd0);
    chk("rst mem_we",       {63'd0, mem_we},       64'd0);
    chk("rst mem_addr",     mem_addr,              64'd0);
    chk("rst mem_wdata",    mem_wdata,             64'd0);
    chk_rsp(0, '0);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    prev_kind = 0; prev_data = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].da, vecs[i].we, vecs[i].wd);
      #1;
      chk("vec if_req_ready", {63'd0, if_req_ready}, {63'd0, vecs[i].e_ir});
      chk("vec d_req_ready",  {63'd0, d_req_ready},  {63'd0, vecs[i].e_dr});
      chk("vec mem_en",       {63'd0, mem_en},       {63'd0, vecs[i].e_en});
      chk("vec mem_we",       {63'd0, mem_we},       {63'd0, vecs[i].e_we});
      chk("vec mem_addr",     mem_addr,              vecs[i].e_addr);
      chk_rsp(prev_kind, prev_data);
      prev_kind = vecs[i].e_kind;
      prev_data = vecs[i].e_data;
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    #1;
    chk_rsp(prev_kind, prev_data);

    // Both requesters valid continuously.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 64'h8, 1'b1, 64'h10, 1'b0, '0);
      #1;
`ifdef ARB_STARVE_GUARD_EN
      chk("starve if_req_ready", {63'd0, if_req_ready}, {63'd0, (i % 5) == 4});
`else
      chk("starve if_req_ready", {63'd0, if_req_ready}, 64'd0);
`endif
      chk("starve one grant", {63'd0, if_req_ready ^ d_req_ready}, 64'd1);
    end

    // Reset lands after a read was granted: its response must vanish.
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 64'h0, 1'b0, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    #1;
    chk("rst mid d_rsp_valid", {63'd0, d_rsp_valid}, 64'd0);
    chk("rst mid busy",        {63'd0, busy},        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk_rsp(0, '0);
    end

    // Random traffic against the reference model.
    do_reset();
    prev_kind = 0; prev_data = '0; starve_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      logic        iv, dv, we, force_if, eg_i, eg_d, inr;
      logic [63:0] ia, da, wd, e_dw;
      int          ii, di, r;
      @(negedge clk);
      iv = ($urandom_range(0, 2) != 0);
      dv = ($urandom_range(0, 2) != 0);
      r  = $urandom_range(0, 19);
      ii = (r >= 16) ? 4096 + r - 16 : r;
      r  = $urandom_range(0, 19);
      di = (r >= 16) ? 4096 + r - 16 : r;
      ia = 64'(ii) * 8 + 64'($urandom_range(0, 1)) * 4;
      da = 64'(di) * 8 + 64'($urandom_range(0, 7));
      we = $urandom_range(0, 1);
      wd = {$urandom, $urandom};
      drive(iv, ia, dv, da, we, wd);
`ifdef ARB_STARVE_GUARD_EN
      force_if = (starve_cnt >= 4);
`else
      force_if = 1'b0;
`endif
      eg_d = dv && !(force_if && iv);
      eg_i = iv && !eg_d;
      e_dw = eg_d ? 64'(di) : (eg_i ? 64'(ii) : 64'd0);
      inr  = (eg_d && di < 4096) || (eg_i && ii < 4096);
      #1;
      chk("rnd if_req_ready", {63'd0, if_req_ready}, {63'd0, eg_i});
      chk("rnd d_req_ready",  {63'd0, d_req_ready},  {63'd0, eg_d});
      chk("rnd mem_en",       {63'd0, mem_en},       {63'd0, inr});
      chk("rnd mem_we",       {63'd0, mem_we},       {63'd0, inr && eg_d && we});
      chk("rnd mem_addr",     mem_addr,              e_dw);
      if (eg_d && we) chk("rnd mem_wdata", mem_wdata, wd);
      chk_rsp(prev_kind, prev_data);

      prev_kind = 0; prev_data = '0;
      if (eg_d) begin
        prev_kind = 2;
        if (we) begin
          if (di < 16) ref_mem[di] = wd;
        end else if (di < 16) begin
          prev_data = ref_mem[di];
        end
      end else if (eg_i) begin
        prev_kind = 1;
        if (ii < 16) prev_data = ia[2] ? {32'd0, ref_mem[ii][63:32]} : {32'd0, ref_mem[ii][31:0]};
      end
      if (eg_i) starve_cnt = 0;
      else if (iv && starve_cnt < 15) starve_cnt++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_DWORDS, default 4096: memory depth in 64-bit doublewords.
REQ-002 Parameter STARVE_LIMIT, default 4: fetch starvation threshold, in cycles (range 1..15).
REQ-003 Ports, clock and reset first:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Fetch request ports:
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch grant this cycle.
- if_req_addr  in  64  fetch byte address.
REQ-005 Fetch response ports:
- if_rsp_valid  out  1  fetch response.
- if_rsp_data  out  32  instruction word.
REQ-006 Data request ports:
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data grant this cycle.
- d_req_addr  in  64  data byte address.
- d_req_we  in  1  write enable.
- d_req_wdata  in  64  write data.
REQ-007 Data response ports:
- d_rsp_valid  out  1  data response.
- d_rsp_data  out  64  read data; 0 for writes.
REQ-008 Memory-side ports:
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  64  doubleword index (byte address >> 3).
- mem_wdata  out  64  write data.
- mem_rdata  in  64  read data, valid one cycle after a read strobe.
- busy  out  1  response pending.

Function
REQ-009 At most one grant per cycle: a request is accepted in cycle N when its valid and ready are both high.
REQ-010 Ready outputs SHALL be combinational from valids and arbiter state; the granted requester's ready is high and the other's is low.
REQ-011 Default priority: data over fetch.
REQ-012 Accepted in-range access: mem_en=1 in cycle N; mem_we=d_req_we for data grants and 0 for fetch grants; mem_addr=addr>>3.
REQ-013 Out-of-range access (addr>>3 >= MEM_DWORDS):
- mem_en=0.
- Writes are dropped.
- Reads return 0.
- The response is still generated.
REQ-014 Owner register (NONE/IF/D_RD/D_WR) SHALL capture the granted requester in cycle N; the response fires in cycle N+1 only for that owner.
REQ-015 Fetch response: if_rsp_valid=1 in N+1; if_rsp_data=mem_rdata[63:32] if the registered addr[2]=1, else mem_rdata[31:0].
REQ-016 Data read response: d_rsp_valid=1 in N+1 with d_rsp_data=mem_rdata.
REQ-017 Data write response: d_rsp_valid=1 in N+1 with d_rsp_data=0 (acknowledge).
REQ-018 Back-to-back grants SHALL be sustained at one per cycle; response N+1 overlaps grant N+1.
REQ-019 A read at N+1 to an address written at N SHALL return the new data.
REQ-020 Responses SHALL have no backpressure; requesters always accept them.
REQ-021 busy SHALL equal (owner != NONE).
REQ-022 Requests with no valid asserted SHALL NOT change owner or memory state.

Reset
REQ-023 On rst_n low, asynchronously:
- owner=NONE.
- All rsp_valid, mem_en, mem_we and busy=0.
- All data/address outputs=0.
- Starvation counter=0.
REQ-024 Reset asserted mid-operation SHALL discard a pending response; no rsp_valid is produced after release.
REQ-025 While in reset, both ready outputs SHALL be 0.

Configuration
REQ-026 Macro ARB_STARVE_GUARD_EN controls the starvation guard. When defined:
- A 4-bit counter increments each cycle if_req_valid=1 and fetch is not granted.
- The counter clears on a fetch grant.
- When the counter reaches STARVE_LIMIT, the next cycle with both valids high SHALL grant fetch.
REQ-027 When ARB_STARVE_GUARD_EN is undefined: strict data priority, no counter logic, and fetch can starve indefinitely.

Verification
REQ-028 Fetch only: if_req_addr=0x4 with mem[0]=0xAAAAAAAA_BBBBBBBB -> mem_en in N; if_rsp_valid in N+1 with if_rsp_data=0xAAAAAAAA.
REQ-029 Data write then read: write 0x1100 with data 0x7B; next cycle read 0x1100 -> d_rsp_valid at both N+1 and N+2; second d_rsp_data=0x7B; mem_addr=0x220.
REQ-030 Contention: both valid for 1 cycle -> d_req_ready=1, if_req_ready=0; fetch is granted the following cycle if it is still valid.
REQ-031 Starvation guard, with ARB_STARVE_GUARD_EN and STARVE_LIMIT=4, both valid continuously -> 4 data grants, then 1 fetch grant, repeating. Without the macro -> fetch is never granted.
REQ-032 Out-of-range: data read at 0x8000 with MEM_DWORDS=4096 -> mem_en=0; d_rsp_valid in N+1 with data 0. Write to 0x8000 -> memory unchanged.
REQ-033 Reset mid-read: grant a read at N, assert rst_n low before N+1 -> d_rsp_valid stays 0, busy=0, and no response after release.
